// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared pipeline-stage state type, control word and bubble constants
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [2:0] imm_sel;
    } rv32i_ctrl_word;

    // Bubble decodes as addi x0, x0, 0 so downstream stages see a harmless NOP.
    localparam rv32i_ctrl_word CTRL_BUBBLE = '{
        alu_op:    4'd0,
        rd:        5'd0,
        reg_write: 1'b1,
        mem_read:  1'b0,
        mem_write: 1'b0,
        branch:    1'b0,
        jump:      1'b0,
        imm_sel:   3'd1
    };

    localparam rv32i_ctrl_word IF_ID_BUBBLE  = CTRL_BUBBLE;
    localparam rv32i_ctrl_word ID_EX_BUBBLE  = CTRL_BUBBLE;
    localparam rv32i_ctrl_word EX_MEM_BUBBLE = CTRL_BUBBLE;
    localparam rv32i_ctrl_word MEM_WB_BUBBLE = CTRL_BUBBLE;

    function automatic logic [1:0] state_count(input pipe_state_t s);
        case (s)
            FULL:    return 2'd1;
            SKID:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and optional skid entry
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter bit               SKID      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_q <= RESET_VAL;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_no_skid
            assign skid_q = RESET_VAL;
        end
    endgenerate

    // Flush wins over every transition; a beat accepted in the flush cycle is silently dropped.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire && SKID) begin
                        skid_d  = in_data;
                        state_d = pipe_stage_reg_pkg::SKID;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                pipe_stage_reg_pkg::SKID: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // In skid mode in_ready depends on state only, breaking the out_ready -> in_ready path.
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        count     = state_count(state_q);
        if (SKID) begin
            in_ready = (state_q != pipe_stage_reg_pkg::SKID);
        end else begin
            in_ready = (state_q == EMPTY) | out_ready;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg in skid and single-entry modes
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int               A_W  = 32;
    localparam logic [A_W-1:0]   A_RV = 32'hDEAD_BEEF;
    localparam int               B_W  = $bits(rv32i_ctrl_word);
    localparam logic [B_W-1:0]   B_RV = CTRL_BUBBLE;

    logic           clk = 1'b0;
    logic           rst_n, flush, in_valid, out_ready;
    logic [31:0]    in_data;
    logic           a_in_ready, a_out_valid;
    logic [A_W-1:0] a_out_data;
    logic [1:0]     a_count;
    logic           b_in_ready, b_out_valid;
    logic [B_W-1:0] b_out_data;
    logic [1:0]     b_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [A_W-1:0] sb_a[$];
    logic [B_W-1:0] sb_b[$];
    int occ_a = 0;
    int occ_b = 0;
    bit clean_a = 1'b1;
    bit clean_b = 1'b1;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(A_W), .SKID(1'b1), .RESET_VAL(A_RV)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
        .count(a_count)
    );

    pipe_stage_reg #(.WIDTH(B_W), .SKID(1'b0), .RESET_VAL(B_RV)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[B_W-1:0]), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
        .count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("a_count",     32'(a_count),     32'(occ_a));
        chk("a_out_valid", 32'(a_out_valid), 32'(occ_a != 0));
        chk("a_in_ready",  32'(a_in_ready),  32'(occ_a < 2));
        chk("b_count",     32'(b_count),     32'(occ_b));
        chk("b_out_valid", 32'(b_out_valid), 32'(occ_b != 0));
        chk("b_in_ready",  32'(b_in_ready),  32'((occ_b == 0) || out_ready));
        if (occ_a == 0 && clean_a) chk("a_reset_data", 32'(a_out_data), 32'(A_RV));
        if (occ_b == 0 && clean_b) chk("b_reset_data", 32'(b_out_data), 32'(B_RV));
    endtask

    // One clock of stimulus: drive after negedge, check, then advance the model at posedge.
    task automatic cycle(input bit fl, input bit iv, input logic [31:0] d, input bit ordy);
        bit ai, ao, bi, bo;
        @(negedge clk);
        flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        check_outputs();
        ai = iv && (occ_a < 2);
        ao = (occ_a != 0) && ordy;
        bi = iv && ((occ_b == 0) || ordy);
        bo = (occ_b != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            occ_a = 0; sb_a.delete(); clean_a = 1'b1;
            occ_b = 0; sb_b.delete(); clean_b = 1'b1;
        end else begin
            occ_a = occ_a + int'(ai) - int'(ao);
            occ_b = occ_b + int'(bi) - int'(bo);
            if (ai) begin sb_a.push_back(d);          clean_a = 1'b0; end
            if (bi) begin sb_b.push_back(d[B_W-1:0]); clean_b = 1'b0; end
        end
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        occ_a = 0; sb_a.delete(); clean_a = 1'b1;
        occ_b = 0; sb_b.delete(); clean_b = 1'b1;
        check_outputs();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            flush     = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            #1;
            check_outputs();
        end
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    endtask

    // Monitor: whenever a stage presents data it must match the oldest outstanding beat.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (a_out_valid) begin
                if (sb_a.size() == 0) chk("a_out_unexpected", 32'(a_out_valid), 32'd0);
                else begin
                    chk("a_out_data", 32'(a_out_data), 32'(sb_a[0]));
                    if (out_ready) void'(sb_a.pop_front());
                end
            end
            if (b_out_valid) begin
                if (sb_b.size() == 0) chk("b_out_unexpected", 32'(b_out_valid), 32'd0);
                else begin
                    chk("b_out_data", 32'(b_out_data), 32'(sb_b[0]));
                    if (out_ready) void'(sb_b.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        do_reset(2);

        // streaming at full rate
        cycle(0, 1, 32'h11, 1); cycle(0, 1, 32'h22, 1); cycle(0, 1, 32'h33, 1);
        repeat (2) cycle(0, 0, 32'h0, 1);

        // back-pressure: fill skid, third beat refused, then drain in order
        cycle(0, 1, 32'hA, 0); cycle(0, 1, 32'hB, 0); cycle(0, 1, 32'hC, 0);
        repeat (2) cycle(0, 1, 32'hC, 1);
        repeat (2) cycle(0, 0, 32'h0, 1);

        // simultaneous fire while FULL
        cycle(0, 1, 32'h4, 0); cycle(0, 1, 32'h5, 1);
        repeat (2) cycle(0, 0, 32'h0, 1);

        // flush while full with concurrent in_fire and out_fire
        cycle(0, 1, 32'h1, 0); cycle(0, 1, 32'h2, 0); cycle(1, 1, 32'h77, 1);
        repeat (2) cycle(0, 0, 32'h0, 0);

        rand_cycles(400);

        // asynchronous reset mid-stream with the skid entry occupied
        cycle(1, 0, 32'h0, 0);
        cycle(0, 1, 32'h123, 0); cycle(0, 1, 32'h456, 0);
        do_reset(3);

        rand_cycles(200);
        repeat (4) cycle(0, 0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
